// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, frame constants and baud divider helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = 10;
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with first-word fall-through read port
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
  end
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed from a byte FIFO, frames sent back-to-back
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = DIV < 2 ? 1 : $clog2(DIV);
  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: CLK_FREQ/BAUD must be >= 2");
  end
  state_t        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, ovf_q;
  logic [7:0]    dout;
  logic          empty, pop, bit_end;
  assign bit_end  = baud_q == CW'(DIV - 1);
  // The head is consumed from IDLE or exactly at the end of a stop bit, giving gapless frames.
  assign pop      = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign busy     = state_q != IDLE || !empty;
  assign tx       = tx_q;
  assign overflow = ovf_q;
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (wr_en),
    .pop  (pop),
    .din  (wr_data),
    .dout (dout),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en && full) ovf_q <= 1'b1;
      baud_q <= bit_end ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (!empty) begin
            state_q <= START;
            shift_q <= dout;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: if (bit_end) begin
          state_q <= DATA;
          tx_q    <= shift_q[0];
        end
        DATA: if (bit_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            bit_q   <= bit_q + 3'd1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
        STOP: if (bit_end) begin
          if (!empty) begin
            state_q <= START;
            shift_q <= dout;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end else begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, bursts, overflow, reset and default baud
module tb_uart_tx_fifo;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] wr_data = '0, wr_data2 = '0;
  logic       wr_en = 1'b0, wr_en2 = 1'b0;
  logic       full, overflow, busy, tx;
  logic       full2, overflow2, busy2, tx2;
  int         n_checks = 0, n_errors = 0;
  logic [7:0] dec;
  always #5 clk = ~clk;
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .overflow(overflow), .busy(busy), .tx(tx)
  );
  uart_tx_fifo dut_def (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data2), .wr_en(wr_en2),
    .full(full2), .overflow(overflow2), .busy(busy2), .tx(tx2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [7:0] d);
    wr_data = d;
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask
  // Compares tx every cycle of a frame starting at cycle skip and decodes bit centres.
  task automatic check_frame(input logic [7:0] b, input int skip, input string tag,
                             input bit sel, input int div, output logic [7:0] d);
    logic [9:0] f;
    logic       o;
    f = {1'b1, b, 1'b0};
    d = '0;
    for (int j = skip; j < 10 * div; j++) begin
      tick(1);
      o = sel ? tx2 : tx;
      chk(tag, 32'(o), 32'(f[j / div]));
      if (j / div >= 1 && j / div <= 8 && j % div == div / 2) d[j / div - 1] = o;
    end
  endtask
  initial begin
    tick(2);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_def", 32'(tx2), 1);
    rst_n = 1'b1;
    tick(2);
    chk("idle_tx", 32'(tx), 1);
    wr(8'hA5);
    chk("a5_busy_rise", 32'(busy), 1);
    chk("a5_tx_pre", 32'(tx), 1);
    check_frame(8'hA5, 0, "a5_frame", 1'b0, 10, dec);
    chk("a5_dec", 32'(dec), 32'hA5);
    chk("a5_busy_stop", 32'(busy), 1);
    tick(1);
    chk("a5_busy_fall", 32'(busy), 0);
    chk("a5_tx_idle", 32'(tx), 1);
    tick(3);
    wr(8'h31);
    wr(8'h32);
    chk("burst_start1", 32'(tx), 0);
    wr(8'h33);
    chk("burst_start2", 32'(tx), 0);
    check_frame(8'h31, 2, "burst_f1", 1'b0, 10, dec);
    chk("burst_dec1", 32'(dec), 32'h31);
    check_frame(8'h32, 0, "burst_f2", 1'b0, 10, dec);
    chk("burst_dec2", 32'(dec), 32'h32);
    check_frame(8'h33, 0, "burst_f3", 1'b0, 10, dec);
    chk("burst_dec3", 32'(dec), 32'h33);
    tick(1);
    chk("burst_busy_fall", 32'(busy), 0);
    tick(3);
    for (int i = 0; i < 10; i++) begin
      wr(8'(8'h40 + i));
      chk("fill_full", 32'(full), 32'(i >= 8));
      chk("fill_ovf", 32'(overflow), 32'(i == 9));
    end
    check_frame(8'h40, 9, "fill_f0", 1'b0, 10, dec);
    chk("fill_dec0", 32'(dec), 32'h40);
    chk("fill_full_hold", 32'(full), 1);
    for (int i = 1; i < 9; i++) begin
      check_frame(8'(8'h40 + i), 0, "fill_f", 1'b0, 10, dec);
      chk("fill_dec", 32'(dec), 32'(8'h40 + i));
      if (i == 1) chk("fill_full_drop", 32'(full), 0);
    end
    tick(1);
    chk("fill_busy_fall", 32'(busy), 0);
    chk("fill_ovf_sticky", 32'(overflow), 1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("fill_no_10th", 32'(tx), 1);
    end
    wr(8'h11);
    tick(5);
    wr(8'h22);
    tick(94);
    chk("sim_stop_tx", 32'(tx), 1);
    wr(8'h33);
    chk("sim_busy", 32'(busy), 1);
    chk("sim_full", 32'(full), 0);
    chk("sim_start", 32'(tx), 0);
    check_frame(8'h22, 1, "sim_fy", 1'b0, 10, dec);
    chk("sim_decy", 32'(dec), 32'h22);
    check_frame(8'h33, 0, "sim_fz", 1'b0, 10, dec);
    chk("sim_decz", 32'(dec), 32'h33);
    tick(1);
    chk("sim_busy_fall", 32'(busy), 0);
    wr(8'hFF);
    wr(8'hFF);
    tick(30);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("post_rst_tx", 32'(tx), 1);
      chk("post_rst_busy", 32'(busy), 0);
    end
    wr(8'h0D);
    check_frame(8'h0D, 0, "post_rst_f", 1'b0, 10, dec);
    chk("post_rst_dec", 32'(dec), 32'h0D);
    tick(1);
    chk("post_rst_idle", 32'(busy), 0);
    wr_data2 = 8'h55;
    wr_en2 = 1'b1;
    tick(1);
    wr_en2 = 1'b0;
    chk("def_busy", 32'(busy2), 1);
    check_frame(8'h55, 0, "def_frame", 1'b1, 868, dec);
    chk("def_dec", 32'(dec), 32'h55);
    tick(1);
    chk("def_busy_fall", 32'(busy2), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synthesizable UART transmitter with a byte FIFO. It accepts bytes from on-chip logic and serialises them on the board TX pin as 8N1 frames: start bit 0, 8 data bits LSB first, stop bit 1. It is the design-side source for the UART receive path on the bench and the board, and frames back-to-back bytes with no idle gap.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 8: byte entries; must be a power of two, ≥2.
- `clk  input  1`: system clock; all logic is rising-edge.
- `rst_n  input  1`: reset. One clock; reset is asynchronous and active-low.
- `wr_data  input  8`: byte to enqueue.
- `wr_en  input  1`: enqueue request, single-cycle qualifier.
- `full  output  1`: FIFO full; writes are dropped while high.
- `overflow  output  1`: sticky flag, set by a write attempted while `full`; cleared only by reset.
- `busy  output  1`: high while a frame is in flight or the FIFO is non-empty.
- `tx  output  1`: serial line; idles high.

## Operation
- Divider: `DIV = CLK_FREQ/BAUD`, integer truncation (868 at the defaults). `DIV` must be ≥2; elaboration fails otherwise.
- Write accept: `wr_en && !full` at a rising edge stores `wr_data` at the tail. If `wr_en && full`, the byte is discarded and `overflow` is set to 1.
- FSM states and transitions:
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the bit counter and baud counter, and go to START.
  - START: `tx=0` for `DIV` cycles, then go to DATA.
  - DATA: `tx=shift[0]` for `DIV` cycles per bit. After each bit, shift right and increment the bit index (0..7). After bit 7, go to STOP.
  - STOP: `tx=1` for `DIV` cycles. At the end of the stop bit: if the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
- `tx` comes straight from a register; it is never driven combinationally.
- Simultaneous write and pop in the same cycle: both take effect. The count is unchanged. `full` is evaluated on the pre-edge count, so a write when `full` is dropped even if a pop happens in the same cycle.
- Baud counter runs 0..DIV-1 and wraps. The bit index is 3 bits. FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count register is one bit wider than the pointers.

## Timing
- Reset values: `tx=1`, `full=0`, `overflow=0`, `busy=0`. FSM goes to IDLE; FIFO pointers and count go to 0; counters go to 0.
- Reset mid-frame: `tx` goes high asynchronously, the frame is abandoned and queued bytes are lost.
- Latency, idle case: a write accepted at edge k gives `tx` falling at edge k+1. `busy` rises at edge k.
- Frame length is exactly `10*DIV` cycles.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit. There are zero idle cycles between frames.
- `full` asserts on the edge where the count reaches `FIFO_DEPTH`. It deasserts on the edge of the next pop.
- `busy` falls on the edge that ends the last stop bit, when the FIFO is empty at that edge.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Frame constants: `DATA_BITS=8`, `FRAME_BITS=10`.
  - Function `baud_div(clk_freq, baud)`.
- Sub-module `uart_sync_fifo` (parameters: width, depth):
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Registered storage with first-word fall-through `dout`.
- Top level holds the baud counter, bit counter, shift register, FSM and the `overflow` flag.

## Test plan
All scenarios use `CLK_FREQ=1_000_000`, `BAUD=100_000` (`DIV=10`) unless stated.
- Single byte 0xA5 written at edge k:
  - `tx`=0 over cycles k+1..k+10.
  - Data bits 1,0,1,0,0,1,0,1, each 10 cycles long.
  - Stop bit 1 for 10 cycles, then `busy` falls.
- Burst 0x31,0x32,0x33 on consecutive cycles:
  - Three contiguous frames, 300 cycles total.
  - No high gap between the stop bit and the next start bit.
  - Decoded bytes in order.
- Fill and overflow with `FIFO_DEPTH=8`: write 10 bytes on consecutive cycles while idle.
  - 1 byte popped immediately, 8 queued, `full` high.
  - 10th write dropped and `overflow`=1.
  - Exactly 9 frames emitted.
- Simultaneous write and pop at a stop-bit boundary with the FIFO holding 1 byte:
  - Count stays 1.
  - Both bytes are transmitted in order.
- Reset asserted mid-DATA of 0xFF:
  - `tx`=1 immediately, `busy`=0.
  - After release, a write of 0x0D produces one clean frame.
- Defaults (100 MHz, 115200): byte 0x55.
  - Each bit lasts 868 cycles.
  - A bit-centre sampling receiver decodes 0x55.
